bram1_arbiter: RTL and testbench

Two-port arbiter that shares one single-port BRAM1 memory between requesters A and B (for example, a CPU data port and a DMA/loader engine). It uses a request/acknowledge handshake on each side and registers the accepted command into a one-stage issue register. It drives the memory's ADDR/DIN/WR pins and returns registered read data with a fixed two-cycle latency. Throughput is one access per cycle.

---
 rtl/bram1_arbiter.sv | 159 +++++++++++++++
 tb/tb_bram1_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bram1_arbiter.sv
// -----------------------------------------------------------------------------
// bram1_arbiter
//   Shares one single-port BRAM1 memory between two requesters (A and B).
//   Each side uses a REQ/ACK handshake; ACK is combinational and pulses in the
//   cycle the request is accepted. The accepted command is registered into a
//   one-stage issue register that drives the memory pins, and the memory's
//   read data is registered one cycle later. Every access (read or write)
//   gets a response exactly two cycles after its ACK. Throughput is one
//   access per cycle.
//
// Configuration macro:
//   BRAM1_ARBITER_RR_EN  defined   -> round-robin on contention (1-bit
//                                     last-served pointer)
//                        undefined -> fixed priority, A always wins
//
// Ports:
//   CLK, RST             clock / asynchronous active-high reset
//   A_REQ/A_WR/A_ADDR/A_DIN   port A command (held until A_ACK)
//   A_ACK                     port A accept (combinational)
//   A_RVALID/A_DOUT           port A response pulse / data
//   B_*                       same as A_* for port B
//   M_ADDR/M_DIN/M_WR         registered memory command
//   M_DOUT                    memory read data (combinational from M_ADDR,
//                             equals M_DIN while M_WR is high)
// -----------------------------------------------------------------------------
module bram1_arbiter #(
  parameter int Waddr = 10,
  parameter int Wdata = 8
) (
  input  logic             CLK,
  input  logic             RST,
  // port A
  input  logic             A_REQ,
  input  logic             A_WR,
  input  logic [Waddr-1:0] A_ADDR,
  input  logic [Wdata-1:0] A_DIN,
  output logic             A_ACK,
  output logic             A_RVALID,
  output logic [Wdata-1:0] A_DOUT,
  // port B
  input  logic             B_REQ,
  input  logic             B_WR,
  input  logic [Waddr-1:0] B_ADDR,
  input  logic [Wdata-1:0] B_DIN,
  output logic             B_ACK,
  output logic             B_RVALID,
  output logic [Wdata-1:0] B_DOUT,
  // memory
  output logic [Waddr-1:0] M_ADDR,
  output logic [Wdata-1:0] M_DIN,
  output logic             M_WR,
  input  logic [Wdata-1:0] M_DOUT
);

  // issue stage
  logic             iss_v_q,  iss_v_d;
  logic             iss_id_q, iss_id_d;   // 0 = A, 1 = B
  logic [Waddr-1:0] m_addr_q, m_addr_d;
  logic [Wdata-1:0] m_din_q,  m_din_d;
  logic             m_wr_q,   m_wr_d;

  // response stage
  logic             rsp_v_q,    rsp_v_d;
  logic             rsp_id_q,   rsp_id_d;
  logic [Wdata-1:0] rsp_data_q, rsp_data_d;

  logic prefer_a;
  logic grant_a;
  logic grant_b;

`ifdef BRAM1_ARBITER_RR_EN
  // 1 = B was served last, so A wins the next contention.
  logic last_b_q, last_b_d;

  always_comb begin
    last_b_d = last_b_q;
    if (grant_b)      last_b_d = 1'b1;
    else if (grant_a) last_b_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) last_b_q <= 1'b1;
    else     last_b_q <= last_b_d;
  end

  assign prefer_a = last_b_q;
`else
  assign prefer_a = 1'b1;
`endif

  // Grant decision. The internal grants feed the issue register directly;
  // while RST is high the registers are held cleared by the async reset, so
  // only the visible ACKs need the explicit reset mask.
  always_comb begin
    grant_a = A_REQ & (~B_REQ | prefer_a);
    grant_b = B_REQ & ~(A_REQ & prefer_a);
  end

  assign A_ACK = grant_a & ~RST;
  assign B_ACK = grant_b & ~RST;

  // Issue stage: capture the winner's command; address/data hold when idle.
  always_comb begin
    iss_v_d  = grant_a | grant_b;
    iss_id_d = grant_b;
    m_addr_d = m_addr_q;
    m_din_d  = m_din_q;
    m_wr_d   = 1'b0;
    if (grant_a) begin
      m_addr_d = A_ADDR;
      m_din_d  = A_DIN;
      m_wr_d   = A_WR;
    end else if (grant_b) begin
      m_addr_d = B_ADDR;
      m_din_d  = B_DIN;
      m_wr_d   = B_WR;
    end
  end

  // Response stage: writes also respond, M_DOUT then mirrors M_DIN.
  always_comb begin
    rsp_v_d    = iss_v_q;
    rsp_id_d   = iss_id_q;
    rsp_data_d = rsp_data_q;
    if (iss_v_q) rsp_data_d = M_DOUT;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      iss_v_q    <= 1'b0;
      iss_id_q   <= 1'b0;
      m_addr_q   <= '0;
      m_din_q    <= '0;
      m_wr_q     <= 1'b0;
      rsp_v_q    <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      iss_v_q    <= iss_v_d;
      iss_id_q   <= iss_id_d;
      m_addr_q   <= m_addr_d;
      m_din_q    <= m_din_d;
      m_wr_q     <= m_wr_d;
      rsp_v_q    <= rsp_v_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign M_ADDR   = m_addr_q;
  assign M_DIN    = m_din_q;
  assign M_WR     = m_wr_q;

  assign A_RVALID = rsp_v_q & ~rsp_id_q;
  assign B_RVALID = rsp_v_q &  rsp_id_q;
  assign A_DOUT   = rsp_data_q;
  assign B_DOUT   = rsp_data_q;

endmodule

// File: tb/tb_bram1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram1_arbiter
//   Directed bench for bram1_arbiter with an attached BRAM1 model. Stimulus
//   pushes the expected response (port, data, due cycle) when it expects a
//   grant; a monitor pops and compares whenever an RVALID appears.
// -----------------------------------------------------------------------------
module tb_bram1_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       A_REQ = 1'b0, A_WR = 1'b0;
  logic [9:0] A_ADDR = '0;
  logic [7:0] A_DIN = '0;
  logic       A_ACK, A_RVALID;
  logic [7:0] A_DOUT;
  logic       B_REQ = 1'b0, B_WR = 1'b0;
  logic [9:0] B_ADDR = '0;
  logic [7:0] B_DIN = '0;
  logic       B_ACK, B_RVALID;
  logic [7:0] B_DOUT;
  logic [9:0] M_ADDR;
  logic [7:0] M_DIN;
  logic       M_WR;
  logic [7:0] M_DOUT;

  bram1_arbiter #(.Waddr(10), .Wdata(8)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WR(A_WR), .A_ADDR(A_ADDR), .A_DIN(A_DIN),
    .A_ACK(A_ACK), .A_RVALID(A_RVALID), .A_DOUT(A_DOUT),
    .B_REQ(B_REQ), .B_WR(B_WR), .B_ADDR(B_ADDR), .B_DIN(B_DIN),
    .B_ACK(B_ACK), .B_RVALID(B_RVALID), .B_DOUT(B_DOUT),
    .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_WR(M_WR), .M_DOUT(M_DOUT)
  );

  always #5 CLK = ~CLK;

  // BRAM1 model: contents start as the low address byte.
  logic [7:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
  always @(posedge CLK) if (M_WR) mem[M_ADDR] <= M_DIN;
  assign M_DOUT = M_WR ? M_DIN : mem[M_ADDR];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       port;   // 0 = A, 1 = B
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic prev_wr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: responses must arrive in order, on the due cycle, on the right port.
  always @(negedge CLK) begin
    if (!RST) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rsp actual none required port %0d data %0h due %0d",
                 q[0].port, q[0].data, q[0].due);
        void'(q.pop_front());
      end
      chk("rvalid_exclusive", {31'd0, A_RVALID & B_RVALID}, 32'd0);
      if (A_RVALID || B_RVALID) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual A_RVALID %0d B_RVALID %0d required none",
                   A_RVALID, B_RVALID);
        end else begin
          e = q.pop_front();
          chk("rsp_port",  {31'd0, B_RVALID}, {31'd0, e.port});
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_dout",  {24'd0, (B_RVALID ? B_DOUT : A_DOUT)}, {24'd0, e.data});
          chk("rsp_dout_shared", {24'd0, (B_RVALID ? A_DOUT : B_DOUT)}, {24'd0, e.data});
        end
      end
    end
  end

  // One cycle of stimulus: drive, check ACKs/M_WR at mid-cycle, queue expectations.
  task automatic step(input logic ar, input logic aw, input logic [9:0] aa, input logic [7:0] ad,
                      input logic br, input logic bw, input logic [9:0] ba, input logic [7:0] bd,
                      input logic ea, input logic eb, input logic [7:0] xa, input logic [7:0] xb,
                      input string nm);
    A_REQ = ar; A_WR = aw; A_ADDR = aa; A_DIN = ad;
    B_REQ = br; B_WR = bw; B_ADDR = ba; B_DIN = bd;
    @(negedge CLK);
    chk({nm, " A_ACK"}, {31'd0, A_ACK}, {31'd0, ea});
    chk({nm, " B_ACK"}, {31'd0, B_ACK}, {31'd0, eb});
    chk({nm, " M_WR"},  {31'd0, M_WR},  {31'd0, prev_wr});
    if (ea) q.push_back('{1'b0, xa, cyc + 2});
    if (eb) q.push_back('{1'b1, xb, cyc + 2});
    prev_wr = (ea && aw) || (eb && bw);
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'h00, "idle");
  endtask

  initial begin
    // Reset with both ports requesting: nothing may be granted or driven.
    A_REQ = 1; A_ADDR = 10'h041;
    B_REQ = 1; B_ADDR = 10'h081;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("rst A_ACK",    {31'd0, A_ACK},    32'd0);
      chk("rst B_ACK",    {31'd0, B_ACK},    32'd0);
      chk("rst M_ADDR",   {22'd0, M_ADDR},   32'd0);
      chk("rst M_DIN",    {24'd0, M_DIN},    32'd0);
      chk("rst M_WR",     {31'd0, M_WR},     32'd0);
      chk("rst A_RVALID", {31'd0, A_RVALID}, 32'd0);
      chk("rst B_RVALID", {31'd0, B_RVALID}, 32'd0);
      chk("rst A_DOUT",   {24'd0, A_DOUT},   32'd0);
      chk("rst B_DOUT",   {24'd0, B_DOUT},   32'd0);
    end
    @(posedge CLK); #1;
    RST = 0;

    // Contention straight out of reset: A goes first in both builds.
`ifdef BRAM1_ARBITER_RR_EN
    step(1, 0, 10'h041, 8'h00, 1, 0, 10'h081, 8'h00, 1, 0, 8'h41, 8'h00, "rr0");
    step(1, 0, 10'h042, 8'h00, 1, 0, 10'h081, 8'h00, 0, 1, 8'h00, 8'h81, "rr1");
    step(1, 0, 10'h042, 8'h00, 1, 0, 10'h082, 8'h00, 1, 0, 8'h42, 8'h00, "rr2");
    step(1, 0, 10'h043, 8'h00, 1, 0, 10'h082, 8'h00, 0, 1, 8'h00, 8'h82, "rr3");
    step(0, 0, 10'h043, 8'h00, 1, 0, 10'h083, 8'h00, 0, 1, 8'h00, 8'h83, "rr4");
`else
    step(1, 0, 10'h041, 8'h00, 1, 0, 10'h081, 8'h00, 1, 0, 8'h41, 8'h00, "fp0");
    step(1, 0, 10'h042, 8'h00, 1, 0, 10'h081, 8'h00, 1, 0, 8'h42, 8'h00, "fp1");
    step(1, 0, 10'h043, 8'h00, 1, 0, 10'h081, 8'h00, 1, 0, 8'h43, 8'h00, "fp2");
    step(1, 0, 10'h044, 8'h00, 1, 0, 10'h081, 8'h00, 1, 0, 8'h44, 8'h00, "fp3");
    step(0, 0, 10'h044, 8'h00, 1, 0, 10'h081, 8'h00, 0, 1, 8'h00, 8'h81, "fp4");
`endif
    idle(2);

    // Write then immediate read of the same address (no forwarding needed).
    step(1, 1, 10'h010, 8'h5A, 0, 0, 10'h000, 8'h00, 1, 0, 8'h5A, 8'h00, "wr010");
    step(1, 0, 10'h010, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 8'h5A, 8'h00, "rd010");
    idle(2);

    // Cross-port coherence at the top address.
    step(0, 0, 10'h000, 8'h00, 1, 1, 10'h3FF, 8'hC3, 0, 1, 8'h00, 8'hC3, "bwr3ff");
    step(1, 0, 10'h3FF, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 8'hC3, 8'h00, "ard3ff");
    idle(2);

    // Reset while a write sits in the issue stage: the write must be dropped.
    step(1, 1, 10'h020, 8'h77, 0, 0, 10'h000, 8'h00, 1, 0, 8'h77, 8'h00, "wr020");
    chk("pre_rst M_WR", {31'd0, M_WR}, 32'd1);
    A_WR = 0;
    #1;
    RST = 1;
    q.delete();
    #1;
    chk("midrst M_WR",   {31'd0, M_WR},  32'd0);
    chk("midrst M_ADDR", {22'd0, M_ADDR}, 32'd0);
    chk("midrst A_ACK",  {31'd0, A_ACK}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("midrst A_ACK held", {31'd0, A_ACK},    32'd0);
      chk("midrst A_RVALID",   {31'd0, A_RVALID}, 32'd0);
      chk("midrst B_RVALID",   {31'd0, B_RVALID}, 32'd0);
    end
    @(posedge CLK); #1;
    RST = 0;
    prev_wr = 1'b0;
    step(1, 0, 10'h020, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 8'h20, 8'h00, "rd020_old");
    idle(3);

    chk("drain", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
